// File: rtl/hex8_scan_ctrl.sv
// Eight-digit seven-segment scan scheduler feeding hc595_driver, with frame-synchronous update buffering.
// Optional feature macro: HEX8_BLANK_LEADING_ZERO_EN (suppress leading zero digits 1..7).
module hex8_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] disp_data,
    input  logic [7:0]  disp_en,
    input  logic [7:0]  dp,
    input  logic        load,
    output logic [15:0] data,
    output logic        s_en,
    output logic [2:0]  digit_idx
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SCAN  = 1'b1
    } state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     idx_q, idx_next_s;
    logic [15:0]    data_q, word_s;
    logic           sen_q;
    logic [31:0]    p_data_q, p_data_d, a_data_q, a_data_d;
    logic [7:0]     p_en_q, p_en_d, a_en_q, a_en_d;
    logic [7:0]     p_dp_q, p_dp_d, a_dp_q, a_dp_d;
    logic           pend_q, pend_d;
    logic           tick_s, boundary_s;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    function automatic logic [15:0] encode(input logic [31:0] d, input logic [7:0] en,
                                           input logic [7:0] dpm, input logic [2:0] k);
        logic [3:0] nib;
        logic       blank;
        nib   = d[{k, 2'b00} +: 4];
        blank = ~en[k];
`ifdef HEX8_BLANK_LEADING_ZERO_EN
        // Nibbles k..7 all zero and no decimal point: this is a leading zero.
        if ((k != 3'd0) && !dpm[k] && ((d >> {k, 2'b00}) == 32'd0)) begin
            blank = 1'b1;
        end else begin
            blank = blank;
        end
`endif
        if (blank) begin
            return 16'hFFFF;
        end else begin
            return {~dpm[k], seg7(nib), ~(8'd1 << k)};
        end
    endfunction

    // Prescaler, frame boundary detection, buffer next-state and next word.
    always_comb begin
        tick_s     = (cnt_q == CNT_LAST);
        idx_next_s = idx_q + 3'd1;
        boundary_s = tick_s && (idx_q == 3'd7);
        cnt_d      = tick_s ? {CW{1'b0}} : (cnt_q + CW'(1));
        p_data_d   = p_data_q;
        p_en_d     = p_en_q;
        p_dp_d     = p_dp_q;
        pend_d     = pend_q;
        a_data_d   = a_data_q;
        a_en_d     = a_en_q;
        a_dp_d     = a_dp_q;
        if (boundary_s) begin
            // A load in the boundary cycle bypasses the pending set and wins over it.
            if (load) begin
                a_data_d = disp_data;
                a_en_d   = disp_en;
                a_dp_d   = dp;
            end else if (pend_q) begin
                a_data_d = p_data_q;
                a_en_d   = p_en_q;
                a_dp_d   = p_dp_q;
            end else begin
                a_data_d = a_data_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            p_data_d = disp_data;
            p_en_d   = disp_en;
            p_dp_d   = dp;
            pend_d   = 1'b1;
        end else begin
            pend_d = pend_q;
        end
        word_s = encode(a_data_d, a_en_d, a_dp_d, idx_next_s);
    end

    // Prescaler and display buffers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= {CW{1'b0}};
            p_data_q <= 32'd0;
            p_en_q   <= 8'd0;
            p_dp_q   <= 8'd0;
            pend_q   <= 1'b0;
            a_data_q <= 32'd0;
            a_en_q   <= 8'd0;
            a_dp_q   <= 8'd0;
        end else begin
            cnt_q    <= cnt_d;
            p_data_q <= p_data_d;
            p_en_q   <= p_en_d;
            p_dp_q   <= p_dp_d;
            pend_q   <= pend_d;
            a_data_q <= a_data_d;
            a_en_q   <= a_en_d;
            a_dp_q   <= a_dp_d;
        end
    end

    // Scan FSM with registered data, s_en and digit index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_BLANK;
            idx_q   <= 3'd7;
            data_q  <= 16'hFFFF;
            sen_q   <= 1'b0;
        end else begin
            sen_q <= tick_s;
            case (state_q)
                ST_BLANK: begin
                    if (tick_s) begin
                        state_q <= ST_SCAN;
                        idx_q   <= idx_next_s;
                        data_q  <= word_s;
                    end else begin
                        data_q  <= 16'hFFFF;
                    end
                end
                ST_SCAN: begin
                    if (tick_s) begin
                        idx_q  <= idx_next_s;
                        data_q <= word_s;
                    end else begin
                        data_q <= data_q;
                    end
                end
                default: begin
                    state_q <= ST_BLANK;
                    idx_q   <= 3'd7;
                    data_q  <= 16'hFFFF;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign s_en      = sen_q;
    assign digit_idx = idx_q;

endmodule
